// File: rtl/bs_gnrtr_rr_n_arbtr.sv
// Multi-bus packet generator/arbiter: BITS independent buses, each with a round-robin
// IDLE/POP/PUSH FSM routing by destination ID. Optional broadcast via BS_BROADCAST_EN.
module bs_gnrtr_rr_n_arbtr #(
  parameter int          BITS      = 1,
  parameter int          DRVRS     = 4,
  parameter int          PCKG_SZ   = 16,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [BITS-1:0][DRVRS-1:0]             pndng,
  input  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop,
  output logic [BITS-1:0][DRVRS-1:0]             pop,
  output logic [BITS-1:0][DRVRS-1:0]             push,
  output logic [BITS-1:0][PCKG_SZ-1:0]           D_push,
  output logic [15:0]                            drop_cnt
);

  localparam int IW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  logic [BITS-1:0] drop;

  genvar gi;
  generate
    for (gi = 0; gi < BITS; gi++) begin : g_bus
      state_t             state_reg, state_next;
      logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
      logic [IW-1:0]      src_reg, src_next;
      logic [PCKG_SZ-1:0] pkt_reg, pkt_next;
      logic [PCKG_SZ-1:0] d_push_reg, d_push_next;
      logic [DRVRS-1:0]   pop_reg, pop_next;
      logic [DRVRS-1:0]   push_reg, push_next;
      logic [IW-1:0]      sel;
      logic               sel_vld;
      logic [IW:0]        idx;
      logic [7:0]         dst;
      logic               bus_drop;

      // First requester at or after rr_ptr, wrapping modulo DRVRS.
      always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < DRVRS; i++) begin
          idx = {1'b0, rr_ptr_reg} + (IW+1)'(i);
          if (idx >= (IW+1)'(DRVRS))
            idx = idx - (IW+1)'(DRVRS);
          if (!sel_vld && pndng[gi][idx[IW-1:0]]) begin
            sel     = idx[IW-1:0];
            sel_vld = 1'b1;
          end
        end
      end

      assign dst = pkt_reg[PCKG_SZ-1 -: 8];

      always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        src_next    = src_reg;
        pkt_next    = pkt_reg;
        d_push_next = d_push_reg;
        pop_next    = '0;
        push_next   = '0;
        bus_drop    = 1'b0;
        case (state_reg)
          IDLE: begin
            if (sel_vld) begin
              src_next   = sel;
              pkt_next   = D_pop[gi][sel];
              state_next = POP;
            end
          end
          POP: begin
            pop_next    = DRVRS'(1) << src_reg;
            rr_ptr_next = (src_reg == IW'(DRVRS-1)) ? '0 : src_reg + 1'b1;
            state_next  = PUSH;
          end
          PUSH: begin
            d_push_next = pkt_reg;
            if (int'(dst) < DRVRS) begin
              push_next = DRVRS'(1) << dst;
            end else if (dst == BROADCAST) begin
`ifdef BS_BROADCAST_EN
              push_next = ~(DRVRS'(1) << src_reg);
`else
              bus_drop  = 1'b1;
`endif
            end else begin
              bus_drop = 1'b1;
            end
            state_next = IDLE;
          end
          default: state_next = IDLE;
        endcase
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_reg  <= IDLE;
          rr_ptr_reg <= '0;
          src_reg    <= '0;
          pkt_reg    <= '0;
          d_push_reg <= '0;
          pop_reg    <= '0;
          push_reg   <= '0;
        end else begin
          state_reg  <= state_next;
          rr_ptr_reg <= rr_ptr_next;
          src_reg    <= src_next;
          pkt_reg    <= pkt_next;
          d_push_reg <= d_push_next;
          pop_reg    <= pop_next;
          push_reg   <= push_next;
        end
      end

      assign pop[gi]    = pop_reg;
      assign push[gi]   = push_reg;
      assign D_push[gi] = d_push_reg;
      assign drop[gi]   = bus_drop;
    end
  endgenerate

  // Several buses may drop in one cycle; add them all, then clamp.
  logic [17:0] ndrop;
  logic [17:0] drop_sum;
  logic [15:0] drop_cnt_reg, drop_cnt_next;

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < BITS; i++)
      ndrop = ndrop + 18'(drop[i]);
    drop_sum      = 18'(drop_cnt_reg) + ndrop;
    drop_cnt_next = (drop_sum > 18'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      drop_cnt_reg <= '0;
    else
      drop_cnt_reg <= drop_cnt_next;
  end

  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_bs_gnrtr_rr_n_arbtr.sv
// Directed bench for bs_gnrtr_rr_n_arbtr (8 buses x 4 devices); broadcast expectation
// follows BS_BROADCAST_EN.
module tb_bs_gnrtr_rr_n_arbtr;

  logic                          clk = 1'b0;
  logic                          reset;
  logic [7:0][3:0]               pndng;
  logic [7:0][3:0][15:0]         D_pop;
  logic [7:0][3:0]               pop;
  logic [7:0][3:0]               push;
  logic [7:0][15:0]              D_push;
  logic [15:0]                   drop_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_drop;

  always #5 clk = ~clk;

  bs_gnrtr_rr_n_arbtr #(
    .BITS(8), .DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    pndng = '0;
    D_pop = '0;

    // Reset then idle
    @(negedge clk);
    chk("rst_pop_push", {pop, push}, 64'h0);
    chk("rst_drop", 64'(drop_cnt), 64'h0);
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("idle_pop_push", {pop, push}, 64'h0);
    end
    chk("idle_dpush_lo", D_push[3:0], 64'h0);
    chk("idle_dpush_hi", D_push[7:4], 64'h0);
    chk("idle_drop", 64'(drop_cnt), 64'h0);
    $display("reset/idle done");

    // Unicast: bus 0 device 1 -> device 2
    pndng[0][1] = 1'b1;
    D_pop[0][1] = 16'h02AB;
    step();
    chk("uni_pop_early", 64'(pop[0]), 64'h0);
    step();
    chk("uni_pop", 64'(pop[0]), 64'h2);
    pndng[0][1] = 1'b0;
    step();
    chk("uni_push", 64'(push[0]), 64'h4);
    chk("uni_dpush", 64'(D_push[0]), 64'h02AB);
    chk("uni_pop_off", 64'(pop[0]), 64'h0);
    step();
    chk("uni_push_off", 64'(push[0]), 64'h0);
    chk("uni_dpush_hold", 64'(D_push[0]), 64'h02AB);
    $display("unicast 0->bus0 dev1 to dev2 done");

    // Round robin from rr_ptr = 0 with devices 0,1,3 requesting
    reset = 1'b1; step(); reset = 1'b0;
    D_pop[0][0] = 16'h0010;
    D_pop[0][1] = 16'h0011;
    D_pop[0][3] = 16'h0013;
    pndng[0] = 4'b1011;
    for (int s = 0; s < 6; s++) begin
      logic [3:0] exp_pop;
      case (s % 3)
        0:       exp_pop = 4'b0001;
        1:       exp_pop = 4'b0010;
        default: exp_pop = 4'b1000;
      endcase
      step();
      step();
      chk("rr_pop", 64'(pop[0]), 64'(exp_pop));
      step();
      chk("rr_push", 64'(push[0]), 64'h1);
      $display("rr slot %0d pop=%b", s, pop[0]);
    end
    pndng[0] = '0;
    D_pop[0] = '0;

    // Invalid destination
    pndng[0][0] = 1'b1;
    D_pop[0][0] = 16'h07FF;
    step(); step();
    chk("inv_pop", 64'(pop[0]), 64'h1);
    pndng[0][0] = 1'b0;
    step();
    chk("inv_push", 64'(push[0]), 64'h0);
    chk("inv_drop", 64'(drop_cnt), 64'h1);
    exp_drop = 16'd1;
    $display("invalid id drop done");

    // Broadcast from device 2
    pndng[0][2] = 1'b1;
    D_pop[0][2] = 16'hFF55;
    step(); step();
    chk("bc_pop", 64'(pop[0]), 64'h4);
    pndng[0][2] = 1'b0;
    step();
`ifdef BS_BROADCAST_EN
    chk("bc_push", 64'(push[0]), 64'hB);
`else
    chk("bc_push", 64'(push[0]), 64'h0);
    exp_drop = exp_drop + 16'd1;
`endif
    chk("bc_dpush", 64'(D_push[0]), 64'hFF55);
    chk("bc_drop", 64'(drop_cnt), 64'(exp_drop));
    $display("broadcast done");

    // Two buses drop in the same cycle
    pndng[0][0] = 1'b1; D_pop[0][0] = 16'h07FF;
    pndng[1][3] = 1'b1; D_pop[1][3] = 16'h05AA;
    step(); step();
    chk("mb_pop0", 64'(pop[0]), 64'h1);
    chk("mb_pop1", 64'(pop[1]), 64'h8);
    pndng = '0;
    step();
    chk("mb_push", 64'({push[1], push[0]}), 64'h0);
    chk("mb_drop", 64'(drop_cnt), 64'(exp_drop + 16'd2));
    $display("multi-bus drop done");

    // Reset asserted while in POP
    pndng[0][1] = 1'b1; D_pop[0][1] = 16'h0200;
    step();
    reset = 1'b1;
    pndng = '0;
    step();
    reset = 1'b0;
    step(); step();
    chk("rpop_pop_push", {pop, push}, 64'h0);
    chk("rpop_drop", 64'(drop_cnt), 64'h0);
    chk("rpop_dpush", D_push[3:0], 64'h0);

    // Reset asserted while pop is high (in PUSH) clears outputs at once
    pndng[0][1] = 1'b1; D_pop[0][1] = 16'h0200;
    step(); step();
    chk("rpush_pop_before", 64'(pop[0]), 64'h2);
    reset = 1'b1;
    #1;
    chk("rpush_pop_async", 64'(pop[0]), 64'h0);
    pndng = '0;
    step();
    reset = 1'b0;
    step(); step();
    chk("rpush_push", {pop, push}, 64'h0);
    chk("rpush_dpush", 64'(D_push[0]), 64'h0);
    $display("mid-transfer reset done");

    // Saturation: all 8 buses drop continuously, 8 per 3-cycle slot
    for (int b = 0; b < 8; b++) begin
      pndng[b][0] = 1'b1;
      D_pop[b][0] = 16'h07FF;
    end
    for (int s = 0; s < 8191; s++) begin
      step(); step(); step();
    end
    chk("sat_pre", 64'(drop_cnt), 64'hFFF8);
    step(); step(); step();
    chk("sat_hit", 64'(drop_cnt), 64'hFFFF);
    step(); step(); step();
    chk("sat_hold", 64'(drop_cnt), 64'hFFFF);
    pndng = '0;
    $display("saturation done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
